// File: rtl/logic_unit_arbiter_pkg.sv
// rtl/logic_unit_arbiter_pkg.sv - shared op and FSM encodings for the logic unit arbiter
package logic_unit_arbiter_pkg;

    localparam logic [1:0] OP_NOT = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_OR  = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_RESP = 2'b10
    } state_t;

endpackage

// File: rtl/logic_unit_arbiter_bitwise_unit16.sv
// rtl/logic_unit_arbiter_bitwise_unit16.sv - combinational 16-bit NOT/AND/OR/XOR unit
module bitwise_unit16
    import logic_unit_arbiter_pkg::*;
(
    output logic [15:0] out,
    input  logic [1:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b
);

    logic [15:0] not_out;
    logic [15:0] and_out;
    logic [15:0] or_out;
    logic [15:0] xor_out;

    // gate-level bitwise results, all computed in parallel
    assign not_out = ~a;
    assign and_out = a & b;
    assign or_out  = a | b;
    assign xor_out = a ^ b;

    // 4:1 result mux selected by the op code
    always_comb begin
        out = not_out;
        case (op)
            OP_NOT:  out = not_out;
            OP_AND:  out = and_out;
            OP_OR:   out = or_out;
            OP_XOR:  out = xor_out;
            default: out = not_out;
        endcase
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// rtl/logic_unit_arbiter.sv - round-robin arbiter sharing one bitwise unit; optional LOGIC_ARB_GRANT_CNT_EN grant counters
module logic_unit_arbiter
    import logic_unit_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int W    = 16
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [2*NREQ-1:0]   req_op,
    input  logic [W*NREQ-1:0]   req_a,
    input  logic [W*NREQ-1:0]   req_b,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [W-1:0]        rsp_data
`ifdef LOGIC_ARB_GRANT_CNT_EN
    ,
    output logic [8*NREQ-1:0]   grant_cnt
`endif
);

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] gnt;
    logic [IDW-1:0] idx;
    logic           any_valid;
    logic [IDW-1:0] lat_id;
    logic [1:0]     lat_op;
    logic [W-1:0]   lat_a;
    logic [W-1:0]   lat_b;
    logic [W-1:0]   unit_out;

    // round-robin search: walk downward so the index nearest ptr+1 wins last
    always_comb begin
        any_valid = 1'b0;
        gnt       = ptr;
        idx       = ptr;
        for (int k = NREQ; k >= 1; k--) begin
            idx = ptr + IDW'(k);
            if (req_valid[idx]) begin
                any_valid = 1'b1;
                gnt       = idx;
            end
        end
    end

    // accept is combinational in IDLE so the grant lands in the same cycle
    always_comb begin
        req_ready = '0;
        if (rst_n && state == S_IDLE && any_valid) begin
            req_ready[gnt] = 1'b1;
        end
    end

    bitwise_unit16 u_unit (
        .out (unit_out),
        .op  (lat_op),
        .a   (lat_a),
        .b   (lat_b)
    );

    // FSM: latch the winner, evaluate once, then hold the response until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ptr       <= IDW'(NREQ - 1);
            lat_id    <= '0;
            lat_op    <= OP_NOT;
            lat_a     <= '0;
            lat_b     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_valid) begin
                        lat_id <= gnt;
                        lat_op <= req_op[2*gnt +: 2];
                        lat_a  <= req_a[W*gnt +: W];
                        lat_b  <= req_b[W*gnt +: W];
                        state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    rsp_data  <= unit_out;
                    rsp_id    <= lat_id;
                    rsp_valid <= 1'b1;
                    state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        ptr       <= lat_id;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef LOGIC_ARB_GRANT_CNT_EN
    // per-requester saturating grant counters, bumped on each accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt <= '0;
        end else if (state == S_IDLE && any_valid) begin
            for (int i = 0; i < NREQ; i++) begin
                if (gnt == IDW'(i) && grant_cnt[8*i +: 8] != 8'hFF) begin
                    grant_cnt[8*i +: 8] <= grant_cnt[8*i +: 8] + 8'd1;
                end
            end
        end
    end
`endif

endmodule
